// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_MUL = 1'b1;

    localparam int ALU_DATA_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first set req bit at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; win_vld low when no request is pending.
// Ports: req (request vector), ptr (search start), win_idx/win_vld (winner).
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W:0]     pos;

    always_comb begin
        // Rotate so that bit 0 of rot corresponds to requester ptr.
        rot     = NUM_REQ'({req, req} >> ptr);
        pos     = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && rot[k]) begin
                pos = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                    pos = pos - (IDX_W + 1)'(NUM_REQ);
                end
                win_idx = pos[IDX_W-1:0];
                win_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one add/multiply ALU among NUM_REQ requesters, round-robin.
// Latency: req seen at edge t -> grant in t+1 -> done pulse + result in t+2; one op per 3 cycles.
// Backpressure: requesters hold req until done; losers simply wait for a later IDLE.
// Ports: clk, reset (async, active-high); req/lock/op per requester; a_flat/b_flat packed
// operands (requester i at [i*DATA_W +: DATA_W]); grant/done one-hot; result; busy (EXEC/DONE).
// Build option: define ARB_LOCK_EN to let lock[winner] keep ownership across operations.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        op,
    input  logic [NUM_REQ*DATA_W-1:0] a_flat,
    input  logic [NUM_REQ*DATA_W-1:0] b_flat,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [IDX_W-1:0]   sel;
    logic               take;
    logic [IDX_W-1:0]   next_ptr;

`ifdef ARB_LOCK_EN
    logic               own_q, own_d;
`else
    logic               lock_unused;
    assign lock_unused = ^lock;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    assign next_ptr = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sel      = pick_idx;
        take     = pick_vld;
`ifdef ARB_LOCK_EN
        own_d    = own_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_LOCK_EN
                // A locked owner with req still high keeps the ALU without a grant gap;
                // otherwise ownership lapses and the normal pick applies this same cycle.
                if (own_q && req[win_q]) begin
                    sel  = win_q;
                    take = 1'b1;
                end
                own_d = 1'b0;
`endif
                if (take) begin
                    win_d        = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel == IDX_W'(i)) begin
                            op_d = op[i];
                            a_d  = a_flat[i*DATA_W +: DATA_W];
                            b_d  = b_flat[i*DATA_W +: DATA_W];
                        end
                    end
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end else begin
                    grant_d = '0;
                end
            end
            EXEC: begin
                // Both forms wrap to DATA_W bits; the product keeps its low half.
                result_d = (op_q == ALU_OP_MUL) ? a_q * b_q : a_q + b_q;
                done_d   = grant_q;
                state_d  = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef ARB_LOCK_EN
                if (lock[win_q]) begin
                    own_d = 1'b1;
                end else begin
                    ptr_d   = next_ptr;
                    grant_d = '0;
                end
`else
                ptr_d   = next_ptr;
                grant_d = '0;
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            win_q    <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef ARB_LOCK_EN
            own_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
`ifdef ARB_LOCK_EN
            own_q    <= own_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter and its rr_picker.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N-1:0]   op;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           busy;

    logic [3:0]     pk_req;
    logic [1:0]     pk_ptr;
    logic [1:0]     pk_idx;
    logic           pk_vld;

    int tests  = 0;
    int fails  = 0;
    int mh_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .op     (op),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .grant  (grant),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    rr_picker #(.NUM_REQ(4), .IDX_W(2)) u_pk (
        .req     (pk_req),
        .ptr     (pk_ptr),
        .win_idx (pk_idx),
        .win_vld (pk_vld)
    );

    task cyc();
        @(posedge clk);
        #1;
    endtask

    task set_op(input int i, input logic o, input logic [7:0] a, input logic [7:0] b);
        op[i]           = o;
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
    endtask

    // Waits (bounded) for a done pulse; d stays 0 on timeout.
    task automatic wait_done(input bit drop, output logic [3:0] d, output logic [7:0] r, output int n);
        d = '0;
        r = '0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            n++;
            if (!$onehot0(grant) || !$onehot0(done)) mh_bad++;
            if (done != 4'b0) begin
                d = done;
                r = result;
                if (drop) req = req & ~done;
                return;
            end
        end
    endtask

    task test_reset();
        reset = 1'b1; req = '0; lock = '0; op = '0; a_flat = '0; b_flat = '0;
        pk_req = '0; pk_ptr = '0;
        #2;
        tests++; if (grant !== 4'b0)  begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
        tests++; if (done !== 4'b0)   begin fails++; $display("FAIL reset_done: got %b want 0000", done); end
        tests++; if (result !== 8'd0) begin fails++; $display("FAIL reset_result: got %0d want 0", result); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        cyc();
        reset = 1'b0;
    endtask

    task test_picker();
        logic [3:0] vr [8];
        logic [1:0] vp [8];
        logic       vv [8];
        logic [1:0] vi [8];
        vr = '{4'b0000, 4'b1111, 4'b1111, 4'b1001, 4'b1001, 4'b0010, 4'b1000, 4'b0110};
        vp = '{2'd0,    2'd0,    2'd2,    2'd3,    2'd1,    2'd3,    2'd0,    2'd3};
        vv = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};
        vi = '{2'd0,    2'd0,    2'd2,    2'd3,    2'd3,    2'd1,    2'd3,    2'd1};
        for (int v = 0; v < 8; v++) begin
            pk_req = vr[v];
            pk_ptr = vp[v];
            #1;
            tests++;
            if (pk_vld !== vv[v] || (vv[v] && pk_idx !== vi[v])) begin
                fails++;
                $display("FAIL picker_vec%0d: got vld=%b idx=%0d want vld=%b idx=%0d", v, pk_vld, pk_idx, vv[v], vi[v]);
            end
        end
    endtask

    task test_single();
        set_op(1, 1'b0, 8'd200, 8'd100);
        req = 4'b0010;
        cyc();
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL single_grant: got %b want 0010", grant); end
        tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        tests++; if (done !== 4'b0)     begin fails++; $display("FAIL single_early_done: got %b want 0000", done); end
        cyc();
        tests++; if (done !== 4'b0010)  begin fails++; $display("FAIL single_done: got %b want 0010", done); end
        tests++; if (result !== 8'd44)  begin fails++; $display("FAIL single_result: got %0d want 44", result); end
        req = 4'b0;
        cyc();
        tests++; if (grant !== 4'b0)    begin fails++; $display("FAIL single_grant_clr: got %b want 0000", grant); end
        tests++; if (done !== 4'b0)     begin fails++; $display("FAIL single_done_clr: got %b want 0000", done); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL single_busy_clr: got %b want 0", busy); end
        tests++; if (result !== 8'd44)  begin fails++; $display("FAIL single_result_hold: got %0d want 44", result); end
    endtask

    task test_mul_trunc();
        int  busy_cnt;
        bit  got;
        busy_cnt = 0;
        got      = 1'b0;
        set_op(0, 1'b1, 8'd20, 8'd13);
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (busy) busy_cnt++;
            if (done != 4'b0) begin
                got = 1'b1;
                tests++; if (done !== 4'b0001) begin fails++; $display("FAIL mul_done: got %b want 0001", done); end
                tests++; if (result !== 8'd4)  begin fails++; $display("FAIL mul_result: got %0d want 4", result); end
                req = 4'b0;
            end
        end
        tests++; if (!got)          begin fails++; $display("FAIL mul_timeout: got no done want one"); end
        tests++; if (busy_cnt != 2) begin fails++; $display("FAIL mul_busy_cycles: got %0d want 2", busy_cnt); end
    endtask

    task test_fairness();
        logic [3:0] d;
        logic [7:0] r;
        int         n;
        logic [7:0] exp_res [4];
        exp_res = '{8'd4, 8'd16, 8'd15, 8'd15};
        reset = 1'b1;
        #1;
        reset = 1'b0;
        set_op(0, 1'b0, 8'd250, 8'd10);
        set_op(1, 1'b1, 8'd16,  8'd17);
        set_op(2, 1'b0, 8'd7,   8'd8);
        set_op(3, 1'b1, 8'd3,   8'd5);
        mh_bad = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            e = 4'b0001 << (k % 4);
            wait_done(1'b0, d, r, n);
            tests++; if (d !== e) begin fails++; $display("FAIL fair_order%0d: got %b want %b", k, d, e); end
            tests++; if (r !== exp_res[k % 4]) begin fails++; $display("FAIL fair_result%0d: got %0d want %0d", k, r, exp_res[k % 4]); end
            tests++; if (n != ((k == 0) ? 2 : 3)) begin fails++; $display("FAIL fair_spacing%0d: got %0d want %0d", k, n, (k == 0) ? 2 : 3); end
        end
        req = 4'b0;
        cyc();
        cyc();
        tests++; if (mh_bad != 0) begin fails++; $display("FAIL fair_multihot: got %0d cycles want 0", mh_bad); end
    endtask

    task test_wrap();
        logic [3:0] d;
        logic [7:0] r;
        int         n;
        set_op(2, 1'b0, 8'd1, 8'd2);
        req = 4'b0100;
        wait_done(1'b1, d, r, n);
        tests++; if (d !== 4'b0100) begin fails++; $display("FAIL wrap_setup: got %b want 0100", d); end
        set_op(0, 1'b0, 8'd1,   8'd1);
        set_op(3, 1'b0, 8'd100, 8'd100);
        req = 4'b1001;
        wait_done(1'b1, d, r, n);
        tests++; if (d !== 4'b1000 || r !== 8'd200) begin fails++; $display("FAIL wrap_first: got %b/%0d want 1000/200", d, r); end
        wait_done(1'b1, d, r, n);
        tests++; if (d !== 4'b0001 || r !== 8'd2)   begin fails++; $display("FAIL wrap_second: got %b/%0d want 0001/2", d, r); end
    endtask

    task test_mid_reset();
        logic [3:0] d;
        logic [7:0] r;
        int         n;
        int         stray;
        stray = 0;
        set_op(2, 1'b1, 8'd9, 8'd9);
        req = 4'b0100;
        cyc();
        cyc();
        tests++; if (grant !== 4'b0100 || busy !== 1'b1) begin fails++; $display("FAIL midrst_exec: got %b/%b want 0100/1", grant, busy); end
        reset = 1'b1;
        #1;
        tests++; if (grant !== 4'b0)  begin fails++; $display("FAIL midrst_grant: got %b want 0000", grant); end
        tests++; if (done !== 4'b0)   begin fails++; $display("FAIL midrst_done: got %b want 0000", done); end
        tests++; if (result !== 8'd0) begin fails++; $display("FAIL midrst_result: got %0d want 0", result); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        cyc();
        reset = 1'b0;
        req   = 4'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (done != 4'b0) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL midrst_stray_done: got %0d pulses want 0", stray); end
        set_op(0, 1'b0, 8'd5, 8'd6);
        req = 4'b1111;
        wait_done(1'b1, d, r, n);
        tests++; if (d !== 4'b0001 || r !== 8'd11) begin fails++; $display("FAIL midrst_next_winner: got %b/%0d want 0001/11", d, r); end
        req = 4'b0;
        cyc();
    endtask

    task test_lock();
        int cnt2;
        int n_ord;
        int gap_bad;
        bit started;
        int ord [4];
        int exp_ord [4];
        logic [7:0] first_res;
`ifdef ARB_LOCK_EN
        exp_ord = '{2, 2, 2, 0};
`else
        exp_ord = '{2, 0, 2, 2};
`endif
        ord = '{-1, -1, -1, -1};
        cnt2 = 0; n_ord = 0; gap_bad = 0; started = 1'b0; first_res = '0;
        set_op(2, 1'b0, 8'd1, 8'd2);
        set_op(0, 1'b1, 8'd3, 8'd4);
        lock = 4'b0100;
        req  = 4'b0101;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (!$onehot0(grant) || !$onehot0(done)) mh_bad++;
            if (grant == 4'b0100) started = 1'b1;
            if (started && cnt2 < 3 && grant !== 4'b0100) gap_bad++;
            if (done != 4'b0) begin
                if (n_ord == 0) first_res = result;
                for (int i = 0; i < 4; i++) if (done[i] && n_ord < 4) ord[n_ord] = i;
                n_ord++;
            end
            if (done[2]) begin
                cnt2++;
                if (cnt2 >= 3) req[2] = 1'b0;
            end else begin
                lock[2] = (cnt2 < 2);
            end
            if (done[0]) req[0] = 1'b0;
            if (req == 4'b0) break;
        end
        lock = 4'b0;
        tests++; if (n_ord != 4) begin fails++; $display("FAIL lock_count: got %0d ops want 4", n_ord); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (ord[k] != exp_ord[k]) begin fails++; $display("FAIL lock_order%0d: got %0d want %0d", k, ord[k], exp_ord[k]); end
        end
        tests++; if (first_res !== 8'd3) begin fails++; $display("FAIL lock_first_result: got %0d want 3", first_res); end
`ifdef ARB_LOCK_EN
        tests++; if (gap_bad != 0) begin fails++; $display("FAIL lock_grant_gap: got %0d cycles want 0", gap_bad); end
`endif
        tests++; if (mh_bad != 0) begin fails++; $display("FAIL lock_multihot: got %0d cycles want 0", mh_bad); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_picker();
        test_single();
        test_mul_trunc();
        test_fairness();
        test_wrap();
        test_mid_reset();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
